// File: rtl/taillight_pkg.sv
// Shared definitions for the taillight front end and sequencer: mode codes,
// switch bit positions and the switch-to-mode priority decode.
package taillight_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    IDLE      = 3'd0,
    HZRD      = 3'd1,
    SIG_L     = 3'd2,
    SIG_R     = 3'd3,
    BRK       = 3'd4,
    BRK_SIG_L = 3'd5,
    BRK_SIG_R = 3'd6
  } mode_e;

  localparam int HZRD_BIT = 0;
  localparam int TURN_BIT = 1;
  localparam int BRK_BIT  = 2;

  // Hazard overrides everything; brake combines with turn; dir=1 means left.
  function automatic mode_e decode_mode(input logic [2:0] sw, input logic dir);
    mode_e m;
    if (sw[HZRD_BIT])                      m = HZRD;
    else if (sw[BRK_BIT] && sw[TURN_BIT])  m = dir ? BRK_SIG_L : BRK_SIG_R;
    else if (sw[BRK_BIT])                  m = BRK;
    else if (sw[TURN_BIT])                 m = dir ? SIG_L : SIG_R;
    else                                   m = IDLE;
    return m;
  endfunction

endpackage

// File: rtl/taillight_input_conditioner_debounce_bit.sv
// Single-bit debouncer: the stable value follows the synced input only after
// DEBOUNCE_CYCLES consecutive differing cycles. TAILLIGHT_DEBOUNCE_BYPASS_EN passes it straight through.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  output logic stable_o
);

`ifdef TAILLIGHT_DEBOUNCE_BYPASS_EN
  assign stable_o = sync_i;
`else
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_i != stable_q) begin
      // The count reaches DEBOUNCE_CYCLES-1 during the last required differing cycle.
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`endif

endmodule

// File: rtl/taillight_input_conditioner.sv
// Taillight front end: sync + debounce of SW[2:0]/KEY[1], registered mode request
// and the pattern step tick. Honours TAILLIGHT_DEBOUNCE_BYPASS_EN via debounce_bit.
module taillight_input_conditioner
  import taillight_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int STEP_CYCLES     = 1000000
) (
  input  logic              ADC_CLK_10,
  input  logic              reset_n,
  input  logic [2:0]        sw_raw,
  input  logic              dir_raw,
  output logic [MODE_W-1:0] mode,
  output logic              mode_chg,
  output logic              step
);

  localparam int STEP_W = $clog2(STEP_CYCLES);

  logic [3:0]        sync1_q, sync2_q;
  logic [3:0]        stable_w;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              chg_q, chg_d;
  logic              step_q, step_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;

  // Bit 3 carries the direction key alongside the three switches.
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {dir_raw, sw_raw};
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (ADC_CLK_10),
      .rst_ni  (reset_n),
      .sync_i  (sync2_q[i]),
      .stable_o(stable_w[i])
    );
  end

  always_comb begin
    mode_d = decode_mode(stable_w[2:0], stable_w[3]);
    chg_d  = (mode_d != mode_q);
    cnt_d  = cnt_q + 1'b1;
    step_d = 1'b0;
    // A mode change restarts the period and suppresses any coincident wrap.
    if (chg_d) begin
      cnt_d = '0;
    end else if (cnt_q == STEP_W'(STEP_CYCLES - 1)) begin
      cnt_d  = '0;
      step_d = 1'b1;
    end
  end

  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= IDLE;
      chg_q  <= 1'b0;
      step_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      chg_q  <= chg_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mode     = mode_q;
  assign mode_chg = chg_q;
  assign step     = step_q;

endmodule

// File: tb/tb_taillight_input_conditioner.sv
// Directed bench for taillight_input_conditioner with an expected-event scoreboard;
// define TAILLIGHT_DEBOUNCE_BYPASS_EN to exercise the bypass build.
module tb_taillight_input_conditioner;
  import taillight_pkg::*;

  localparam int D    = 4;
  localparam int STEP = 10;
`ifdef TAILLIGHT_DEBOUNCE_BYPASS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = D + 3;
`endif

  typedef struct {
    logic [2:0] m;
    int         c;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] sw_raw;
  logic       dir_raw;
  logic [2:0] mode;
  logic       mode_chg;
  logic       step;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_c   = 0;
  ev_t  chg_q[$];
  ev_t  exp_q[$];
  int   step_q[$];

  taillight_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .STEP_CYCLES    (STEP)
  ) dut (
    .ADC_CLK_10(clk),
    .reset_n   (reset_n),
    .sw_raw    (sw_raw),
    .dir_raw   (dir_raw),
    .mode      (mode),
    .mode_chg  (mode_chg),
    .step      (step)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every mode_chg/step cycle shortly after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (mode_chg === 1'b1) chg_q.push_back('{mode, cyc});
    if (step === 1'b1)     step_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pop_chg(input string tag);
    ev_t e, x;
    x = exp_q.pop_front();
    checks++;
    assert (chg_q.size() != 0) else begin
      failures++;
      $error("FAIL %s_present observed=none expected=mode %0d at cycle %0d", tag, x.m, x.c);
    end
    if (chg_q.size() != 0) begin
      e = chg_q.pop_front();
      chk({tag, "_mode"}, 32'(e.m), 32'(x.m));
      chk({tag, "_cycle"}, e.c, x.c);
    end
  endtask

  task automatic pop_step(input string tag, input int exp_c);
    checks++;
    assert (step_q.size() != 0) else begin
      failures++;
      $error("FAIL %s_present observed=none expected=step at cycle %0d", tag, exp_c);
    end
    if (step_q.size() != 0) chk(tag, step_q.pop_front(), exp_c);
  endtask

  task automatic drop_steps_before(input int c);
    while (step_q.size() != 0 && step_q[0] < c) void'(step_q.pop_front());
  endtask

  task automatic do_change(input string tag, input logic [2:0] sw, input logic dir,
                           input logic [2:0] exp_m, input bit align);
    int t, c, n;
    @(negedge clk);
    n = 0;
    while (align && (((cyc + LAT - last_c) % STEP) != 0) && n < 2 * STEP) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    c = t + LAT;
    sw_raw  = sw;
    dir_raw = dir;
    exp_q.push_back('{exp_m, c});
    repeat (LAT + 11) @(negedge clk);
    pop_chg(tag);
    chk({tag, "_mode_now"}, 32'(mode), 32'(exp_m));
    drop_steps_before(c);
    pop_step({tag, "_step"}, c + STEP);
    last_c = c;
  endtask

  initial begin
    int r, t;
    reset_n = 1'b0;
    sw_raw  = 3'b111;
    dir_raw = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_mode", 32'(mode), 32'(IDLE));
      chk("rst_chg", 32'(mode_chg), 0);
      chk("rst_step", 32'(step), 0);
    end
    sw_raw = 3'b000;
    @(negedge clk);
    reset_n = 1'b1;
    r = cyc;
    repeat (25) @(negedge clk);
    pop_step("rst_step1", r + STEP);
    pop_step("rst_step2", r + 2 * STEP);
    chk("rst_no_chg", chg_q.size(), 0);

    do_change("clean", 3'b001, 1'b1, HZRD, 1'b0);

    do_change("sweep_sig_l",  3'b010, 1'b1, SIG_L,     1'b0);
    do_change("sweep_sig_r",  3'b010, 1'b0, SIG_R,     1'b0);
    do_change("sweep_brk",    3'b100, 1'b0, BRK,       1'b0);
    do_change("sweep_bsig_l", 3'b110, 1'b1, BRK_SIG_L, 1'b0);
    do_change("sweep_bsig_r", 3'b110, 1'b0, BRK_SIG_R, 1'b0);
    do_change("sweep_hzrd",   3'b111, 1'b1, HZRD,      1'b0);
    do_change("to_idle",      3'b000, 1'b1, IDLE,      1'b0);

`ifndef TAILLIGHT_DEBOUNCE_BYPASS_EN
    @(negedge clk);
    sw_raw = 3'b100;
    repeat (3) @(negedge clk);
    sw_raw = 3'b000;
    repeat (12) @(negedge clk);
    chk("glitch3_chg_count", chg_q.size(), 0);
    chk("glitch3_mode", 32'(mode), 32'(IDLE));

    @(negedge clk);
    t = cyc;
    sw_raw = 3'b100;
    exp_q.push_back('{BRK,  t + 7});
    exp_q.push_back('{IDLE, t + 11});
    repeat (4) @(negedge clk);
    sw_raw = 3'b000;
    repeat (18) @(negedge clk);
    pop_chg("glitch4_on");
    pop_chg("glitch4_off");
    drop_steps_before(t + 11);
    pop_step("glitch4_step", t + 11 + STEP);
    last_c = t + 11;
`else
    @(negedge clk);
    t = cyc;
    sw_raw = 3'b001;
    exp_q.push_back('{HZRD, t + 3});
    exp_q.push_back('{IDLE, t + 4});
    @(negedge clk);
    sw_raw = 3'b000;
    repeat (15) @(negedge clk);
    pop_chg("bypass_on");
    pop_chg("bypass_off");
    drop_steps_before(t + 4);
    pop_step("bypass_step", t + 4 + STEP);
    last_c = t + 4;
`endif

    do_change("collide", 3'b001, 1'b1, HZRD, 1'b1);

    @(negedge clk);
    sw_raw  = 3'b110;
    dir_raw = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_pre_mode", 32'(mode), 32'(HZRD));
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_mode", 32'(mode), 32'(IDLE));
    chk("midrst_chg", 32'(mode_chg), 0);
    chk("midrst_step", 32'(step), 0);
    sw_raw = 3'b000;
    chk("midrst_no_chg", chg_q.size(), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    r = cyc;
    step_q.delete();
    repeat (22) @(negedge clk);
    pop_step("midrst_step1", r + STEP);
    pop_step("midrst_step2", r + 2 * STEP);
    chk("midrst_after_chg", chg_q.size(), 0);
    chk("midrst_after_mode", 32'(mode), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/taillight_input_conditioner.md
# taillight_input_conditioner

Upstream front end of the sequential-taillight controller on the DE10-Lite. It synchronizes and debounces the hazard, turn, brake switches and the left/right direction key, and decodes them into a registered 3-bit mode request. It also generates the step tick that advances the light pattern, and feeds both directly into the taillight sequencer FSM that drives LEDR/HEX5.

## Interface
- `DEBOUNCE_CYCLES`, default 200000: consecutive stable cycles required to accept an input change (20 ms at 10 MHz); must be ≥2.
- `STEP_CYCLES`, default 1000000: step tick period in clocks (100 ms); must be ≥2.
- `ADC_CLK_10`  in  1  sole clock, 10 MHz.
- `reset_n`  in  1  asynchronous, active-low reset, driven from KEY[0].
- `sw_raw`  in  3  raw SW[2:0]: [0]=hazard, [1]=turn, [2]=brake; asynchronous to the clock.
- `dir_raw`  in  1  raw KEY[1]: 1=left, 0=right; asynchronous.
- `mode`  out  3  registered mode request, encoded per the package.
- `mode_chg`  out  1  one-cycle pulse, high in the first cycle a new `mode` value is presented.
- `step`  out  1  one-cycle pattern-advance pulse.

## Operation
- **Synchronizer.** Each of the 4 raw inputs passes through 2 flops. All flops reset to 0.
- **Debounce (per bit).**
  - Each bit has a stable register, reset 0, and a counter.
  - While the synced value equals stable, the counter holds 0.
  - While they differ, the counter increments each cycle.
  - Stable takes the synced value on the edge that completes the `DEBOUNCE_CYCLES`-th consecutive differing cycle; the counter clears on that same edge.
  - Any cycle where synced equals stable clears the counter, so glitches shorter than `DEBOUNCE_CYCLES` are discarded.
- **Decode (priority order, from the stable bits):**
  - hazard=1 → HZRD (1), regardless of all other inputs.
  - brake=1 and turn=1 → BRK_SIG_L (5) if dir=1, BRK_SIG_R (6) if dir=0.
  - brake=1 and turn=0 → BRK (4).
  - turn=1 → SIG_L (2) if dir=1, SIG_R (3) if dir=0.
  - otherwise → IDLE (0).
- **Mode register.** Loads the decoded value every cycle. `mode_chg` is asserted when the decoded value differs from the current `mode`; it goes high on the same edge `mode` updates.
- **Step counter.**
  - Free-running over 0..`STEP_CYCLES`-1; `step` is registered and high for the cycle after the counter equals `STEP_CYCLES`-1.
  - On a mode change, the counter clears to 0 and `step` is forced to 0 for that edge. A new pattern therefore always gets a full first period.
  - If a mode change and a wrap coincide, the mode change wins: no step, counter set to 0.
- The tick runs in every mode, IDLE included; the sequencer ignores it there.
- **Reset.** Asserting `reset_n` mid-debounce or mid-period clears all state immediately: `mode`=IDLE, `mode_chg`=0, `step`=0, counters 0, stable bits 0 (which reads as dir=right).

## Timing
- Input-to-`mode` latency: 2 (sync) + `DEBOUNCE_CYCLES` + 1 (mode register) clock edges after the raw change is sampled.
- `mode_chg` is coincident with the new `mode`.
- First `step` after reset release: `STEP_CYCLES` cycles later. Subsequent steps every `STEP_CYCLES` cycles until the next mode change.
- A new period starts the cycle after `mode_chg`; the next `step` comes `STEP_CYCLES` cycles after `mode_chg`.
- Outputs are all registered, with no combinational path from the inputs.

## Configuration
- `TAILLIGHT_DEBOUNCE_BYPASS_EN` defined: the debounce counters are removed and stable equals synced directly, giving input-to-`mode` latency of 3 cycles. Intended for fast simulation; the synchronizer, decode and step logic are unchanged.
- Not defined: full debounce as specified above. This is the synthesis default.

## Structure
- `taillight_pkg` holds:
  - the `MODE_W`=3 constant;
  - the mode codes IDLE, HZRD, SIG_L, SIG_R, BRK, BRK_SIG_L, BRK_SIG_R (0–6), shared with the sequencer;
  - the SW bit-index constants HZRD_BIT, TURN_BIT, BRK_BIT.
- Sub-module `debounce_bit`: parameter `DEBOUNCE_CYCLES`, ports clock, reset, synced input, stable output. It is instantiated 4 times, and the bypass macro is honoured inside it.

## Test plan
All cases use `DEBOUNCE_CYCLES`=4, `STEP_CYCLES`=10, macro undefined unless noted.
- **Reset:** hold `reset_n`=0 with sw_raw=3'b111 → `mode`=0, `mode_chg`=0, `step`=0 throughout; after release, first `step` at cycle 10, then every 10 cycles.
- **Clean change:** sw_raw=3'b001 → `mode`=1 with a one-cycle `mode_chg`, exactly 7 edges after the change; step counter restarts and the next `step` is 10 cycles after `mode_chg`.
- **Decode sweep:** dir/sw_raw = 1/010, 0/010, x/100, 1/110, 0/110, 1/111 → `mode` = 2, 3, 4, 5, 6, 1.
- **Glitch rejection:** sw_raw[2] pulsed high for 3 cycles → `mode` stays 0, no `mode_chg`. The same pulse held for 4 or more cycles → `mode`=4.
- **Collision and mid-op reset:**
  - Align a mode change with a counter wrap → no `step`, counter=0.
  - Assert `reset_n` mid-debounce → all outputs 0 immediately.
- **Bypass:** `TAILLIGHT_DEBOUNCE_BYPASS_EN` defined, 1-cycle-wide sw_raw[0] pulse → `mode`=1 after 3 edges, then back to 0.
